fwd_hazard_ctrl: RTL
====================

Name: fwd_hazard_ctrl

Overview:
- Forwarding and hazard controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
- Tracks destination-register tags for the EX, MEM and WB stages internally.
- Drives the 2-bit selects of the two ID-stage 4:1 32-bit operand bypass muxes (rs and rt).
- Detects load-use and HI/LO multiply/divide hazards, stalls ID and injects EX bubbles.

Parameters:
- RA_W, 5, register address width.
- MD_LAT, 32, cycles from mult/div issue until HI/LO results are valid (1..63).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- id_rs  in  RA_W  ID-stage rs address
- id_rt  in  RA_W  ID-stage rt address
- id_rs_used  in  1  instruction in ID reads rs
- id_rt_used  in  1  instruction in ID reads rt
- id_dest  in  RA_W  ID-stage destination register
- id_wen  in  1  ID instruction writes GPR
- id_is_load  in  1  ID instruction is a load
- id_md_start  in  1  ID instruction is mult/multu/div/divu
- id_md_read  in  1  ID instruction is mfhi/mflo
- ext_stall  in  1  global freeze from memory; all tags hold
- flush  in  1  kill the ID instruction (branch/exception)
- fwd_sel_rs  out  2  rs mux select
- fwd_sel_rt  out  2  rt mux select
- stall_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  EX register loads a NOP
- md_busy  out  1  mult/div in progress

Behaviour:
- Select encoding: 00 register file, 01 EX result, 10 MEM result (carries load data), 11 WB result.
- Tag per stage: {valid, dest, wen, is_load}. A stage forwards only when valid & wen & dest != 0 & dest == source & source_used.
- Priority EX > MEM > WB. Register $0 always selects 00.
- Load-use hazard: the EX tag is a load and matches a used source -> stall_id=1, bubble_ex=1. That source's select is a don't-care but is driven 00.
- MD counter: loads MD_LAT when id_md_start is accepted (accepted = not stall_id, not flush, not ext_stall); otherwise decrements to 0 every cycle, ext_stall included.
- md_busy = (counter != 0).
- id_md_read or id_md_start with md_busy=1 -> stall_id=1, bubble_ex=1.
- stall_id = (load_use | md_hazard) & ~flush.
- bubble_ex = stall_id | flush.
- Tag advance each cycle when ext_stall=0:
  - wb <= mem; mem <= ex.
  - ex <= bubble_ex ? invalid : ID tag.
- ext_stall=1: all tags and the counter-load path hold (counter still decrements). Selects remain combinational on the current tags. stall_id still reflects hazards.
- flush and a hazard in the same cycle: flush wins, stall_id=0, EX gets a bubble.
- Outputs are combinational from registered tags and ID inputs; no added latency.
- A stall lasts exactly 1 cycle for load-use. For MD hazards it lasts until the counter reaches 0.
- Reset (async): all tags invalid, counter 0. Outputs fwd_sel_rs=fwd_sel_rt=00, stall_id=0, bubble_ex=0, md_busy=0, given id_* inputs deasserted.
- Reset asserted mid-stall or mid-MD clears immediately; the first post-reset cycle has no forwarding.

Decomposition:
- Shared package: FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11; stage tag struct/width constant; RA_W.
- One natural sub-module, fwd_src_sel: combinational priority compare of one source against three tags. Instantiated twice (rs, rt).

Test Plan:
- add $3 in EX, ID reads rs=$3 -> fwd_sel_rs=01. Next cycle with no stall, the same read -> 10. Following cycle -> 11. Cycle after -> 00.
- lw $5 in EX, ID reads rt=$5 -> stall_id=1, bubble_ex=1 for 1 cycle. Next cycle fwd_sel_rt=10, stall_id=0.
- EX and MEM both write $7, ID reads $7 on rs and rt -> both selects 01. ID write to $0 followed by a read of $0 -> 00.
- mult accepted with MD_LAT=4, mfhi next -> stall_id=1 for 4 cycles, md_busy falls with the counter at 0, then mfhi passes.
- lw-use hazard with flush=1 same cycle -> stall_id=0, bubble_ex=1. With ext_stall=1 for 3 cycles, tags hold and selects are unchanged.
- rst pulsed asynchronously mid-MD (counter=10) and mid-forward -> md_busy=0 and all selects 00 immediately, before the next clock edge.

Source files
------------

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants and stage-tag type for the MIPS forwarding / hazard controller.
package fwd_hazard_ctrl_pkg;

  localparam int unsigned RA_W     = 5;
  localparam int unsigned MD_CNT_W = 6;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] dest;
    logic            wen;
    logic            is_load;
  } stage_tag_t;

  localparam int unsigned TAG_W = $bits(stage_tag_t);

  // A stage can supply a source only if it really writes that non-zero register.
  function automatic logic tag_hit(input stage_tag_t t, input logic [RA_W-1:0] src,
                                   input logic used);
    return t.valid & t.wen & (t.dest != '0) & (t.dest == src) & used;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_src_sel.sv
// Priority bypass select for one ID-stage source operand against the EX/MEM/WB tags.
module fwd_src_sel
  import fwd_hazard_ctrl_pkg::*;
(
  input  logic [RA_W-1:0] src_i,
  input  logic            used_i,
  input  stage_tag_t      ex_i,
  input  stage_tag_t      mem_i,
  input  stage_tag_t      wb_i,
  output logic [1:0]      sel_o,
  output logic            load_hit_o
);

  logic hit_ex, hit_mem, hit_wb;

  assign hit_ex     = tag_hit(ex_i, src_i, used_i);
  assign hit_mem    = tag_hit(mem_i, src_i, used_i);
  assign hit_wb     = tag_hit(wb_i, src_i, used_i);
  assign load_hit_o = hit_ex & ex_i.is_load;

  // Load data is not ready in EX, so a load hit parks the mux on the register file.
  always_comb begin
    sel_o = FWD_RF;
    if (load_hit_o)   sel_o = FWD_RF;
    else if (hit_ex)  sel_o = FWD_EX;
    else if (hit_mem) sel_o = FWD_MEM;
    else if (hit_wb)  sel_o = FWD_WB;
  end

  logic unused_tag_bits;
  assign unused_tag_bits = ^{mem_i.is_load, wb_i.is_load};

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select, load-use and HI/LO hazard control for the 5-stage MIPS pipeline.
module fwd_hazard_ctrl #(
  parameter int unsigned RA_W   = 5,
  parameter int unsigned MD_LAT = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic [RA_W-1:0] id_dest,
  input  logic            id_wen,
  input  logic            id_is_load,
  input  logic            id_md_start,
  input  logic            id_md_read,
  input  logic            ext_stall,
  input  logic            flush,
  output logic [1:0]      fwd_sel_rs,
  output logic [1:0]      fwd_sel_rt,
  output logic            stall_id,
  output logic            bubble_ex,
  output logic            md_busy
);
  import fwd_hazard_ctrl_pkg::*;

  localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MD_LAT);

  stage_tag_t ex_q, mem_q, wb_q, ex_d, id_tag;
  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic load_hit_rs, load_hit_rt, load_use, md_hazard, md_accept;

  fwd_src_sel u_sel_rs (
    .src_i(id_rs), .used_i(id_rs_used), .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q),
    .sel_o(fwd_sel_rs), .load_hit_o(load_hit_rs)
  );

  fwd_src_sel u_sel_rt (
    .src_i(id_rt), .used_i(id_rt_used), .ex_i(ex_q), .mem_i(mem_q), .wb_i(wb_q),
    .sel_o(fwd_sel_rt), .load_hit_o(load_hit_rt)
  );

  assign load_use  = load_hit_rs | load_hit_rt;
  assign md_busy   = (md_cnt_q != '0);
  assign md_hazard = (id_md_read | id_md_start) & md_busy;
  assign stall_id  = (load_use | md_hazard) & ~flush;
  assign bubble_ex = stall_id | flush;
  assign md_accept = id_md_start & ~stall_id & ~flush & ~ext_stall;

  always_comb begin
    id_tag  = '{valid: 1'b1, dest: id_dest, wen: id_wen, is_load: id_is_load};
    ex_d    = bubble_ex ? '0 : id_tag;
    // The countdown keeps running through a memory freeze; only a new load waits.
    md_cnt_d = md_cnt_q;
    if (md_accept)    md_cnt_d = MD_LOAD;
    else if (md_busy) md_cnt_d = md_cnt_q - MD_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
      if (!ext_stall) begin
        wb_q  <= mem_q;
        mem_q <= ex_q;
        ex_q  <= ex_d;
      end
    end
  end

endmodule
